// File: rtl/axi_s6_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axi_s6_mem_slave                                          |
// | AXI4 memory slave terminating NoC slave port 6; one outstanding      |
// | write and one outstanding read, running concurrently.                |
// | Option   : AXI_S6_RANGE_CHECK_EN -> DECERR on out-of-range beats     |
// |            (default: word index wraps modulo MEM_DEPTH).             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module axi_s6_mem_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h6000_0000
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     S6_AWID,
  input  logic [ADDR_WIDTH-1:0]   S6_AWADDR,
  input  logic [3:0]              S6_AWLEN,
  input  logic [2:0]              S6_AWSIZE,
  input  logic [1:0]              S6_AWBURST,
  input  logic                    S6_AWLOCK,
  input  logic [3:0]              S6_AWCACHE,
  input  logic [2:0]              S6_AWPROT,
  input  logic [3:0]              S6_AWQOS,
  input  logic [3:0]              S6_AWREGION,
  input  logic                    S6_AWUSER,
  input  logic                    S6_AWVALID,
  output logic                    S6_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S6_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S6_WSTRB,
  input  logic                    S6_WLAST,
  input  logic                    S6_WUSER,
  input  logic                    S6_WVALID,
  output logic                    S6_WREADY,
  output logic [ID_WIDTH-1:0]     S6_BID,
  output logic [1:0]              S6_BRESP,
  output logic                    S6_BUSER,
  output logic                    S6_BVALID,
  input  logic                    S6_BREADY,
  input  logic [ID_WIDTH-1:0]     S6_ARID,
  input  logic [ADDR_WIDTH-1:0]   S6_ARADDR,
  input  logic [3:0]              S6_ARLEN,
  input  logic [2:0]              S6_ARSIZE,
  input  logic [1:0]              S6_ARBURST,
  input  logic                    S6_ARLOCK,
  input  logic [3:0]              S6_ARCACHE,
  input  logic [2:0]              S6_ARPROT,
  input  logic [3:0]              S6_ARQOS,
  input  logic [3:0]              S6_ARREGION,
  input  logic                    S6_ARUSER,
  input  logic                    S6_ARVALID,
  output logic                    S6_ARREADY,
  output logic [ID_WIDTH-1:0]     S6_RID,
  output logic [DATA_WIDTH-1:0]   S6_RDATA,
  output logic [1:0]              S6_RRESP,
  output logic                    S6_RLAST,
  output logic                    S6_RUSER,
  output logic                    S6_RVALID,
  input  logic                    S6_RREADY
);

  localparam int c_STRB_W   = DATA_WIDTH / 8;
  localparam int c_BYTE_LSB = $clog2(c_STRB_W);
  localparam int c_IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [3:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [2:0]            sz;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    sz   = (size > 3'(c_BYTE_LSB)) ? 3'(c_BYTE_LSB) : size;
    step = c_ONE << sz;
    mask = ((ADDR_WIDTH'(len) + c_ONE) << sz) - c_ONE;
    f_next_addr = addr + step;
    if (burst == 2'b00) begin
      f_next_addr = addr;
    end else if (burst == 2'b10 &&
                 (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
      f_next_addr = (addr & ~mask) | ((addr + step) & mask);
    end
  endfunction

  function automatic logic [c_IDX_W-1:0] f_word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] woff;
    woff = (addr - BASE_ADDR) >> c_BYTE_LSB;
    return c_IDX_W'(woff % ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  // ---------------- write path ----------------
  wstate_t               r_wstate, w_wstate_nxt;
  logic [ID_WIDTH-1:0]   r_wid, r_bid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [3:0]            r_wlen, r_wcnt;
  logic [2:0]            r_wsize;
  logic [1:0]            r_wburst, r_bresp;
  logic                  r_slverr, r_decerr;
  logic                  w_aw_hs, w_wbeat, w_wfinal, w_slv_any, w_dec_any, w_win;
  logic [c_IDX_W-1:0]    w_widx;

  assign w_aw_hs   = S6_AWVALID & S6_AWREADY;
  assign w_wbeat   = S6_WVALID & S6_WREADY;
  assign w_wfinal  = (r_wcnt == r_wlen);
  assign w_slv_any = r_slverr | (S6_WLAST != w_wfinal);
  assign w_dec_any = r_decerr | ~w_win;
  assign w_widx    = f_word_idx(r_waddr);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    S6_AWREADY   = 1'b0;
    S6_WREADY    = 1'b0;
    S6_BVALID    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        S6_AWREADY = 1'b1;
        if (S6_AWVALID) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        S6_WREADY = 1'b1;
        if (S6_WVALID && w_wfinal) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        S6_BVALID = 1'b1;
        if (S6_BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wcnt   <= '0;
      r_slverr <= 1'b0;
      r_decerr <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= 2'b00;
    end else if (w_aw_hs) begin
      r_wid    <= S6_AWID;
      r_waddr  <= S6_AWADDR;
      r_wlen   <= S6_AWLEN;
      r_wsize  <= S6_AWSIZE;
      r_wburst <= S6_AWBURST;
      r_wcnt   <= '0;
      r_slverr <= 1'b0;
      r_decerr <= 1'b0;
    end else if (w_wbeat) begin
      r_waddr  <= f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
      r_wcnt   <= r_wcnt + 4'd1;
      r_slverr <= w_slv_any;
      r_decerr <= w_dec_any;
      // DECERR outranks a WLAST protocol error
      if (w_wfinal) begin
        r_bid   <= r_wid;
        r_bresp <= w_dec_any ? 2'b11 : (w_slv_any ? 2'b10 : 2'b00);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_wbeat && w_win) begin
      for (int b = 0; b < c_STRB_W; b++) begin
        if (S6_WSTRB[b]) r_mem[w_widx][8*b +: 8] <= S6_WDATA[8*b +: 8];
      end
    end
  end

  assign S6_BID   = r_bid;
  assign S6_BRESP = r_bresp;
  assign S6_BUSER = 1'b0;

  // ---------------- read path ----------------
  rstate_t               r_rstate, w_rstate_nxt;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [3:0]            r_rlen, r_rcnt;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;
  logic                  w_ar_hs, w_rbeat, w_rin;
  logic [c_IDX_W-1:0]    w_ridx;

  assign w_ar_hs = S6_ARVALID & S6_ARREADY;
  assign w_rbeat = S6_RVALID & S6_RREADY;
  assign w_ridx  = f_word_idx(r_raddr);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    S6_ARREADY   = 1'b0;
    S6_RVALID    = 1'b0;
    S6_RLAST     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        S6_ARREADY = 1'b1;
        if (S6_ARVALID) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        S6_RVALID = 1'b1;
        S6_RLAST  = (r_rcnt == r_rlen);
        if (S6_RREADY && S6_RLAST) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rcnt   <= '0;
    end else if (w_ar_hs) begin
      r_rid    <= S6_ARID;
      r_raddr  <= S6_ARADDR;
      r_rlen   <= S6_ARLEN;
      r_rsize  <= S6_ARSIZE;
      r_rburst <= S6_ARBURST;
      r_rcnt   <= '0;
    end else if (w_rbeat) begin
      r_raddr <= f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
      r_rcnt  <= r_rcnt + 4'd1;
    end
  end

`ifdef AXI_S6_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] c_SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH * c_STRB_W);

  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, addr - BASE_ADDR};
    return (addr >= BASE_ADDR) && (off < c_SPAN);
  endfunction

  assign w_win = f_in_range(r_waddr);
  assign w_rin = f_in_range(r_raddr);
`else
  assign w_win = 1'b1;
  assign w_rin = 1'b1;
`endif

  // Combinational read: a same-cycle write lands after this beat is taken
  assign S6_RDATA = (r_rstate == R_DATA && w_rin) ? r_mem[w_ridx] : '0;
  assign S6_RRESP = (r_rstate == R_DATA && !w_rin) ? 2'b11 : 2'b00;
  assign S6_RID   = r_rid;
  assign S6_RUSER = 1'b0;

  logic w_unused;
  assign w_unused = ^{S6_AWLOCK, S6_AWCACHE, S6_AWPROT, S6_AWQOS, S6_AWREGION, S6_AWUSER,
                      S6_WUSER, S6_ARLOCK, S6_ARCACHE, S6_ARPROT, S6_ARQOS, S6_ARREGION,
                      S6_ARUSER};

endmodule
`default_nettype wire
